csr_tohost_reader: RTL and testbench

//   Host-side reader of the tohost CSR. Watches CSR writes committed by the pipeline,

---
 rtl/csr_host_pkg.sv | 13 +
 rtl/csr_fifo.sv | 53 +++++
 rtl/csr_tohost_reader.sv | 94 +++++++++
 tb/tb_csr_tohost_reader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/csr_host_pkg.sv
// Shared constants and types for the tohost CSR reader.
// A terminal write carries bit0=1; the value 1 alone means pass.
package csr_host_pkg;

  localparam int CSR_W = 32;
  localparam logic [CSR_W-1:0] TOHOST_PASS = 32'd1;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_e;

endpackage

// File: rtl/csr_fifo.sv
// Synchronous first-word-fall-through FIFO.
// The head is read straight from storage, and a push into an empty FIFO is not bypassed to the output.
module csr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head  = mem_r[rd_ptr_r[AW-1:0]];

  // A simultaneous pop frees the head slot, so a push into a full FIFO is still accepted.
  assign do_push_s = push & (~full | pop);
  assign do_pop_s  = pop & ~empty;

  // Storage and pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        wr_ptr_r                <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

endmodule

// File: rtl/csr_tohost_reader.sv
// Host-side tohost CSR reader: captures committed CSR writes into a FIFO and
// decodes the terminal write into done/pass/fail_code plus a cycle count.
module csr_tohost_reader
  import csr_host_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             csr_we,
  input  logic [CSR_W-1:0] csrd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CSR_W-1:0] out_data,
  output logic             overflow,
  output logic             done,
  output logic             pass,
  output logic [CSR_W-2:0] fail_code,
  output logic [CNT_W-1:0] cycles
);

  state_e           state_r;
  logic             wr_pend_r;
  logic             overflow_r;
  logic             done_r;
  logic             pass_r;
  logic [CSR_W-2:0] fail_code_r;
  logic [CNT_W-1:0] cycles_r;

  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic             terminal_s;
  logic             drop_s;

  // The CSR takes the new value on the write edge, so csrd is stable one edge later.
  assign push_s     = wr_pend_r & (state_r == RUN);
  assign pop_s      = out_valid & out_ready;
  assign terminal_s = push_s & csrd[0];
  assign drop_s     = push_s & full_s & ~pop_s;

  csr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CSR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (csrd),
    .pop       (pop_s),
    .full      (full_s),
    .empty     (empty_s),
    .head      (out_data)
  );

  assign out_valid = ~empty_s;
  assign overflow  = overflow_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail_code = fail_code_r;
  assign cycles    = cycles_r;

  // Write tracking, terminal decode, overflow flag and run-time counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= RUN;
      wr_pend_r   <= 1'b0;
      overflow_r  <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_code_r <= {(CSR_W-1){1'b0}};
      cycles_r    <= {CNT_W{1'b0}};
    end else begin
      wr_pend_r <= csr_we & ~stall;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (terminal_s) begin
        state_r     <= DONE;
        done_r      <= 1'b1;
        pass_r      <= (csrd == TOHOST_PASS);
        fail_code_r <= csrd[CSR_W-1:1];
      end
      // The terminal capture edge itself is still counted.
      if ((state_r == RUN) && (cycles_r != {CNT_W{1'b1}})) begin
        cycles_r <= cycles_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_csr_tohost_reader.sv
// Directed testbench for csr_tohost_reader with a tiny CSR register model driving csrd.
module tb_csr_tohost_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        csr_we;
  logic [31:0] wdata;
  logic [31:0] csrd = 32'd0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        overflow;
  logic        done;
  logic        pass;
  logic [30:0] fail_code;
  logic [31:0] cycles;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  int exp_cyc;

  always #5 clk = ~clk;

  // CSR register as the pipeline would update it
  always @(posedge clk) begin
    if (csr_we && !stall) csrd <= wdata;
  end

  // Edges since the last reset release
  always @(posedge clk) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  csr_tohost_reader #(.DEPTH(4), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .csr_we    (csr_we),
    .csrd      (csrd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow),
    .done      (done),
    .pass      (pass),
    .fail_code (fail_code),
    .cycles    (cycles)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Single write cycle; returns at the negedge after the write edge.
  task automatic do_write(input logic [31:0] data, input logic stl);
    csr_we = 1'b1;
    stall  = stl;
    wdata  = data;
    @(negedge clk);
    csr_we = 1'b0;
    stall  = 1'b0;
  endtask

  logic [31:0] drain_exp [4];

  initial begin
    reset = 1'b1; stall = 1'b0; csr_we = 1'b0; wdata = 32'd0; out_ready = 1'b0;
    drain_exp[0] = 32'h2; drain_exp[1] = 32'h4; drain_exp[2] = 32'h6; drain_exp[3] = 32'h8;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_data", out_data, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_pass", {31'd0, pass}, 32'd0);
    check_eq("rst_fail_code", {1'b0, fail_code}, 32'd0);
    check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
    check_eq("rst_cycles", cycles, 32'd0);

    // 1: counter runs from reset release
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("t1_cycles_%0d", k), cycles, k);
      check_eq("t1_valid", {31'd0, out_valid}, 32'd0);
    end

    // 2: single write appears two edges after the write, then pops
    out_ready = 1'b1;
    do_write(32'h10, 1'b0);
    check_eq("t2_not_yet", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_eq("t2_valid", {31'd0, out_valid}, 32'd1);
    check_eq("t2_data", out_data, 32'h10);
    check_eq("t2_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check_eq("t2_popped", {31'd0, out_valid}, 32'd0);

    // 3: stalled write is not captured
    do_write(32'h20, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check_eq("t3_no_capture", {31'd0, out_valid}, 32'd0);
    end

    // 4: five back-to-back writes into a 4-deep FIFO with no consumer
    out_ready = 1'b0;
    csr_we = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wdata = 32'(2 * i);
      @(negedge clk);
    end
    csr_we = 1'b0;
    check_eq("t4_full_no_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    check_eq("t4_overflow", {31'd0, overflow}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t4_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      check_eq($sformatf("t4_data_%0d", i), out_data, drain_exp[i]);
      @(negedge clk);
    end
    check_eq("t4_empty", {31'd0, out_valid}, 32'd0);

    // 5: pass value terminates the run
    do_write(32'h1, 1'b0);
    @(negedge clk);
    exp_cyc = edge_cnt;
    check_eq("t5_done", {31'd0, done}, 32'd1);
    check_eq("t5_pass", {31'd0, pass}, 32'd1);
    check_eq("t5_fail_code", {1'b0, fail_code}, 32'd0);
    check_eq("t5_cycles", cycles, exp_cyc);
    check_eq("t5_valid", {31'd0, out_valid}, 32'd1);
    check_eq("t5_data", out_data, 32'h1);
    @(negedge clk);
    check_eq("t5_popped", {31'd0, out_valid}, 32'd0);
    do_write(32'h5, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("t5_ignored", {31'd0, out_valid}, 32'd0);
    check_eq("t5_done_hold", {31'd0, done}, 32'd1);
    check_eq("t5_pass_hold", {31'd0, pass}, 32'd1);
    check_eq("t5_cycles_frozen", cycles, exp_cyc);
    check_eq("t5_ovf_sticky", {31'd0, overflow}, 32'd1);

    // 6: failing terminal value, then reset mid-drain
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b0;
    csr_we = 1'b1;
    wdata = 32'h4;
    @(negedge clk);
    wdata = 32'hB;
    @(negedge clk);
    csr_we = 1'b0;
    @(negedge clk);
    check_eq("t6_done", {31'd0, done}, 32'd1);
    check_eq("t6_pass", {31'd0, pass}, 32'd0);
    check_eq("t6_fail_code", {1'b0, fail_code}, 32'd5);
    check_eq("t6_overflow", {31'd0, overflow}, 32'd0);
    check_eq("t6_head0", out_data, 32'h4);
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("t6_head1", out_data, 32'hB);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("t6_rst_data", out_data, 32'd0);
    check_eq("t6_rst_done", {31'd0, done}, 32'd0);
    check_eq("t6_rst_pass", {31'd0, pass}, 32'd0);
    check_eq("t6_rst_fail_code", {1'b0, fail_code}, 32'd0);
    check_eq("t6_rst_cycles", cycles, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t6_restart", cycles, 32'd1);
    do_write(32'h30, 1'b0);
    @(negedge clk);
    check_eq("t6_run_again", out_data, 32'h30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
